capp_sequencer: RTL and testbench
=================================

# capp_sequencer

Command-driven controller for the content-addressable parallel processor array. It owns the comparand and mask registers and accepts one instruction at a time over a valid/ready port. Each instruction is sequenced into cycle-exact control pulses for the compare, cells and tags modules: search, tag set/clear, select-first, read and write. A response carrying the read word and the any-match flag is returned over a valid/ready port.

## Interface
- W, 32, word width of comparand, mask and read/write data
- SEARCH_CYCLES, 2, cycles perform_search is held high; legal range 1..15
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  opcode: 0 NOP, 1 LOAD_CMP, 2 LOAD_MASK, 3 SEARCH, 4 SELECT_FIRST, 5 READ, 6 WRITE, 7 CLEAR
- cmd_data  in  W  operand for LOAD_CMP / LOAD_MASK; ignored otherwise
- comparand  out  W  comparand register, to compare and cells (write data)
- mask  out  W  mask register, to compare and cells (write mask)
- perform_search  out  1  search strobe to compare
- tag_set  out  1  load tags from match lines
- tag_clear  out  1  clear all tags
- select_first  out  1  keep only lowest-index tag
- read_en  out  1  read tagged word onto read lines
- write_en  out  1  write comparand under mask into tagged words
- read_lines  in  W  word from cells
- any_match  in  1  OR of tag bits
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  W  READ result, else 0
- rsp_match  out  1  any_match as sampled at completion

## Operation
- States: IDLE, SRCH, TSET, EXEC, RESP.
- cmd_ready = (state==IDLE) & ~RST. Accept occurs on a rising edge with cmd_valid & cmd_ready; cmd_op and cmd_data are captured at that edge.
- NOP / LOAD_CMP / LOAD_MASK: IDLE->RESP. On the accept edge, comparand (resp. mask) is loaded from cmd_data.
- SEARCH: IDLE->SRCH for SEARCH_CYCLES cycles, then TSET for 1 cycle, then RESP.
- SELECT_FIRST / READ / WRITE / CLEAR: IDLE->EXEC for 1 cycle, then RESP.
- Strobes are registered outputs decoded from state and latched opcode:
  - perform_search is high only in SRCH.
  - tag_set is high only in TSET.
  - select_first, read_en, write_en and tag_clear are each high only in EXEC for their own opcode.
- On entry to RESP:
  - rsp_match <= any_match.
  - rsp_data <= read_lines for READ, else 0.
- RESP: rsp_valid=1. Leave to IDLE on the edge where rsp_ready=1. rsp_data and rsp_match stay stable while rsp_valid && !rsp_ready.
- At most one strobe is high in any cycle. comparand and mask change only on LOAD accepts.

## Timing
- Cycle n = the cycle after the n-th rising edge following the accept edge.
- LOAD_CMP / LOAD_MASK / NOP: register updates in cycle 1; rsp_valid from cycle 1.
- SEARCH:
  - perform_search high in cycles 1..SEARCH_CYCLES.
  - tag_set high in cycle SEARCH_CYCLES+1.
  - rsp_valid from cycle SEARCH_CYCLES+2.
- SELECT_FIRST / READ / WRITE / CLEAR: strobe high in cycle 1; read_lines sampled at the end of cycle 1; rsp_valid from cycle 2.
- If rsp_ready is already high, the response is taken at its first edge. cmd_ready rises the next cycle, so there is no back-to-back accept: minimum spacing is latency+1 cycles.
- cmd_valid while busy is ignored; it is not queued.
- Reset (asynchronous, any time including mid-instruction):
  - state IDLE.
  - All strobes, rsp_valid, rsp_data, rsp_match, comparand and mask are 0.
  - Any pending response is discarded.
  - cmd_ready is 1 in the first cycle after RST falls.

## Test plan
- Reset: assert RST mid-SEARCH (perform_search=1) -> all outputs 0 immediately. After release, cmd_ready=1 and comparand=0, mask=0.
- Load: LOAD_CMP 457, then LOAD_MASK 0x3F -> comparand=457, mask=0x3F. Each rsp_valid comes 1 cycle after accept, with rsp_data=0.
- Search, SEARCH_CYCLES=2, any_match tied 1:
  - perform_search high exactly cycles 1-2, tag_set cycle 3.
  - rsp_valid cycle 4 with rsp_match=1.
  - Repeat with any_match=0 -> rsp_match=0.
- Read: READ with read_lines=0xDEADBEEF -> read_en cycle 1; rsp_valid cycle 2 with rsp_data=0xDEADBEEF.
- Backpressure: WRITE with rsp_ready=0 for 5 cycles:
  - write_en pulses exactly once.
  - rsp_valid and rsp_data stay stable and cmd_ready stays 0 until rsp_ready=1.
  - cmd_ready rises the following cycle.
- Strobe exclusivity: random sequence of 200 opcodes -> never more than one strobe high per cycle. Pulse counts equal the counts of the issued opcodes (SEARCH counts SEARCH_CYCLES perform_search cycles).

Source files
------------

// File: rtl/capp_sequencer.sv
// Instruction sequencer for the content-addressable parallel processor array:
// owns comparand/mask and turns each accepted command into timed control strobes.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// SRCH  | perform_search asserted, search timer counting down
// TSET  | tag_set asserted, match lines loaded into tags
// EXEC  | one-cycle strobe for SELECT_FIRST / READ / WRITE / CLEAR
// RESP  | response held on rsp_* until rsp_ready
module capp_sequencer #(
   parameter int W             = 32,
   parameter int SEARCH_CYCLES = 2
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_op,
   input  logic [W-1:0] cmd_data,
   output logic [W-1:0] comparand,
   output logic [W-1:0] mask,
   output logic         perform_search,
   output logic         tag_set,
   output logic         tag_clear,
   output logic         select_first,
   output logic         read_en,
   output logic         write_en,
   input  logic [W-1:0] read_lines,
   input  logic         any_match,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         rsp_match
);

   typedef enum logic [2:0] {IDLE, SRCH, TSET, EXEC, RESP} state_t;

   localparam logic [2:0] OP_NOP       = 3'd0;
   localparam logic [2:0] OP_LOAD_CMP  = 3'd1;
   localparam logic [2:0] OP_LOAD_MASK = 3'd2;
   localparam logic [2:0] OP_SEARCH    = 3'd3;
   localparam logic [2:0] OP_SELECT    = 3'd4;
   localparam logic [2:0] OP_READ      = 3'd5;
   localparam logic [2:0] OP_WRITE     = 3'd6;
   localparam logic [2:0] OP_CLEAR     = 3'd7;

   localparam logic [3:0] SRCH_TC_LOAD = 4'(SEARCH_CYCLES - 1);

   state_t       state_q, state_d;
   logic [2:0]   op_q, op_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [W-1:0] comparand_q, comparand_d;
   logic [W-1:0] mask_q, mask_d;
   logic [W-1:0] rsp_data_q, rsp_data_d;
   logic         rsp_match_q, rsp_match_d;
   logic [5:0]   strb_q, strb_d;

   assign cmd_ready = (state_q == IDLE) && !RST;
   assign rsp_valid = (state_q == RESP);
   assign comparand = comparand_q;
   assign mask      = mask_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_match = rsp_match_q;
   assign {perform_search, tag_set, tag_clear, select_first, read_en, write_en} = strb_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         op_q        <= OP_NOP;
         cnt_q       <= '0;
         comparand_q <= '0;
         mask_q      <= '0;
         rsp_data_q  <= '0;
         rsp_match_q <= 1'b0;
         strb_q      <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         comparand_q <= comparand_d;
         mask_q      <= mask_d;
         rsp_data_q  <= rsp_data_d;
         rsp_match_q <= rsp_match_d;
         strb_q      <= strb_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      comparand_d = comparand_q;
      mask_d      = mask_q;
      rsp_data_d  = rsp_data_q;
      rsp_match_d = rsp_match_q;
      strb_d      = '0;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_d = cmd_op;
               case (cmd_op)
                  OP_LOAD_CMP: begin
                     comparand_d = cmd_data;
                     state_d     = RESP;
                  end
                  OP_LOAD_MASK: begin
                     mask_d  = cmd_data;
                     state_d = RESP;
                  end
                  OP_SEARCH: begin
                     cnt_d   = SRCH_TC_LOAD;
                     state_d = SRCH;
                  end
                  OP_SELECT, OP_READ, OP_WRITE, OP_CLEAR: state_d = EXEC;
                  default: state_d = RESP;
               endcase
            end
         end
         SRCH: begin
            if (cnt_q == 4'd0) state_d = TSET;
            else               cnt_d   = cnt_q - 4'd1;
         end
         TSET:    state_d = RESP;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Response is captured once on entry so it stays stable under backpressure.
      if (state_d == RESP && state_q != RESP) begin
         rsp_match_d = any_match;
         rsp_data_d  = (op_d == OP_READ) ? read_lines : '0;
      end

      strb_d[5] = (state_d == SRCH);
      strb_d[4] = (state_d == TSET);
      strb_d[3] = (state_d == EXEC) && (op_d == OP_CLEAR);
      strb_d[2] = (state_d == EXEC) && (op_d == OP_SELECT);
      strb_d[1] = (state_d == EXEC) && (op_d == OP_READ);
      strb_d[0] = (state_d == EXEC) && (op_d == OP_WRITE);
   end

endmodule

// File: tb/tb_capp_sequencer.sv
// Bench for capp_sequencer: vector table, reset/backpressure sequences and a
// random opcode run, with responses checked through a scoreboard queue.
module tb_capp_sequencer;
   localparam int W  = 32;
   localparam int SC = 2;

   localparam logic [2:0] NOP = 3'd0, LDC = 3'd1, LDM = 3'd2, SRCH = 3'd3,
                          SELF = 3'd4, RD = 3'd5, WR = 3'd6, CLR = 3'd7;

   logic         CLK, RST;
   logic         cmd_valid, cmd_ready;
   logic [2:0]   cmd_op;
   logic [W-1:0] cmd_data, comparand, mask, read_lines, rsp_data;
   logic         perform_search, tag_set, tag_clear, select_first, read_en, write_en;
   logic         any_match, rsp_valid, rsp_ready, rsp_match;

   capp_sequencer #(.W(W), .SEARCH_CYCLES(SC)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .comparand(comparand), .mask(mask),
      .perform_search(perform_search), .tag_set(tag_set), .tag_clear(tag_clear),
      .select_first(select_first), .read_en(read_en), .write_en(write_en),
      .read_lines(read_lines), .any_match(any_match),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_match(rsp_match)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [W-1:0] d;
      logic         m;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] data;
      logic [W-1:0] rl;
      logic         am;
      int           lat;
      logic [W-1:0] ed;
      logic         em;
      logic [W-1:0] ecmp;
      logic [W-1:0] emask;
   } vec_t;
   vec_t vecs[10];

   int errors = 0;
   int checks = 0;
   int n_ps = 0, n_ts = 0, n_tc = 0, n_sf = 0, n_rd = 0, n_wr = 0;
   logic [W-1:0] cmp_m = '0, mask_m = '0;

   function automatic logic [5:0] strobes();
      return {perform_search, tag_set, tag_clear, select_first, read_en, write_en};
   endfunction

   function automatic int lat_of(input logic [2:0] op);
      if (op == NOP || op == LDC || op == LDM) return 1;
      if (op == SRCH) return SC + 2;
      return 2;
   endfunction

   function automatic logic [5:0] exp_strobe(input logic [2:0] op, input int n);
      if (op == SRCH) begin
         if (n >= 1 && n <= SC) return 6'b100000;
         if (n == SC + 1)       return 6'b010000;
         return 6'b000000;
      end
      if (n != 1) return 6'b000000;
      case (op)
         CLR:     return 6'b001000;
         SELF:    return 6'b000100;
         RD:      return 6'b000010;
         WR:      return 6'b000001;
         default: return 6'b000000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one cycle; outputs are observed at the falling edge.
   task automatic tick();
      logic         hs;
      logic [W-1:0] d;
      logic         m;
      exp_t         e;
      logic [5:0]   s;
      hs = rsp_valid && rsp_ready;
      d  = rsp_data;
      m  = rsp_match;
      @(negedge CLK);
      if (hs) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_rsp", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_data", d, e.d);
            chk("rsp_match", m, e.m);
         end
      end
      s = strobes();
      chk("strobe_onehot", ($countones(s) <= 1), 1);
      n_ps += s[5]; n_ts += s[4]; n_tc += s[3];
      n_sf += s[2]; n_rd += s[1]; n_wr += s[0];
   endtask

   task automatic wait_ready();
      int k;
      for (k = 0; k < 50 && !cmd_ready; k++) tick();
      chk("cmd_ready_timeout", cmd_ready, 1);
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] data,
                          input logic [W-1:0] rl, input logic am, input int lat,
                          input logic [W-1:0] ed, input logic em, input int hold);
      int           n;
      logic         got;
      logic [W-1:0] held_d;
      logic         held_m;
      wait_ready();
      cmd_op     = op;
      cmd_data   = data;
      read_lines = rl;
      any_match  = am;
      rsp_ready  = (hold == 0);
      cmd_valid  = 1'b1;
      sb.push_back({ed, em});
      if (op == LDC) cmp_m  = data;
      if (op == LDM) mask_m = data;
      tick();
      cmd_valid = 1'b0;
      got = 1'b0;
      n   = 1;
      while (n <= 40) begin
         chk($sformatf("strobes_op%0d_c%0d", op, n), strobes(), exp_strobe(op, n));
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
         tick();
         n++;
      end
      chk($sformatf("rsp_seen_op%0d", op), got, 1);
      chk($sformatf("latency_op%0d", op), n, lat);
      held_d = rsp_data;
      held_m = rsp_match;
      if (hold > 0) begin
         // A command offered while busy must be dropped.
         cmd_op    = LDC;
         cmd_data  = 32'hBAD0_BAD0;
         cmd_valid = 1'b1;
         for (int h = 0; h < hold; h++) begin
            tick();
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, held_d);
            chk("bp_rsp_match", rsp_match, held_m);
            chk("bp_cmd_ready", cmd_ready, 0);
         end
         cmd_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      tick();
      chk("post_rsp_cmd_ready", cmd_ready, 1);
      chk("post_rsp_valid", rsp_valid, 0);
      chk("comparand_model", comparand, cmp_m);
      chk("mask_model", mask, mask_m);
   endtask

   initial begin
      int           e_ps, e_ts, e_tc, e_sf, e_rd, e_wr;
      int           wr_before;
      logic [2:0]   op;
      logic [W-1:0] d, rl;
      logic         am;

      vecs[0] = '{LDC,  32'd457,        32'h0,        1'b0, 1,      32'h0,        1'b0, 32'd457,        32'h0};
      vecs[1] = '{LDM,  32'h3F,         32'h0,        1'b1, 1,      32'h0,        1'b1, 32'd457,        32'h3F};
      vecs[2] = '{SRCH, 32'h0,          32'h0,        1'b1, SC + 2, 32'h0,        1'b1, 32'd457,        32'h3F};
      vecs[3] = '{SRCH, 32'h0,          32'h0,        1'b0, SC + 2, 32'h0,        1'b0, 32'd457,        32'h3F};
      vecs[4] = '{SELF, 32'h0,          32'h55,       1'b1, 2,      32'h0,        1'b1, 32'd457,        32'h3F};
      vecs[5] = '{WR,   32'h0,          32'h1234,     1'b0, 2,      32'h0,        1'b0, 32'd457,        32'h3F};
      vecs[6] = '{CLR,  32'h0,          32'h0,        1'b1, 2,      32'h0,        1'b1, 32'd457,        32'h3F};
      vecs[7] = '{NOP,  32'hFFFF_FFFF,  32'h0,        1'b0, 1,      32'h0,        1'b0, 32'd457,        32'h3F};
      vecs[8] = '{LDC,  32'hA5A5_0001,  32'h0,        1'b1, 1,      32'h0,        1'b1, 32'hA5A5_0001,  32'h3F};
      vecs[9] = '{RD,   32'h0,          32'hDEAD_BEEF, 1'b1, 2,     32'hDEAD_BEEF, 1'b1, 32'hA5A5_0001, 32'h3F};

      RST = 1'b1;
      cmd_valid = 1'b0; cmd_op = NOP; cmd_data = '0;
      read_lines = '0; any_match = 1'b0; rsp_ready = 1'b1;
      repeat (2) @(negedge CLK);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_comparand", comparand, 0);
      chk("rst_mask", mask, 0);
      chk("rst_rsp", {strobes(), rsp_valid, rsp_match}, 0);
      chk("rst_rsp_data", rsp_data, 0);
      RST = 1'b0;
      #1;
      chk("rel_cmd_ready", cmd_ready, 1);

      for (int i = 0; i < 10; i++) begin
         run_cmd(vecs[i].op, vecs[i].data, vecs[i].rl, vecs[i].am,
                 vecs[i].lat, vecs[i].ed, vecs[i].em, 0);
         chk($sformatf("vec%0d_comparand", i), comparand, vecs[i].ecmp);
         chk($sformatf("vec%0d_mask", i), mask, vecs[i].emask);
      end

      // Asynchronous reset in the middle of a search.
      wait_ready();
      cmd_op = SRCH; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("mid_search_ps", perform_search, 1);
      #2 RST = 1'b1;
      #1;
      chk("mid_rst_strobes", strobes(), 0);
      chk("mid_rst_rsp", {rsp_valid, rsp_match, cmd_ready}, 0);
      chk("mid_rst_rsp_data", rsp_data, 0);
      chk("mid_rst_comparand", comparand, 0);
      chk("mid_rst_mask", mask, 0);
      @(negedge CLK);
      RST = 1'b0;
      cmp_m = '0; mask_m = '0;
      sb.delete();
      #1;
      chk("after_rst_cmd_ready", cmd_ready, 1);
      chk("after_rst_comparand", comparand, 0);
      chk("after_rst_mask", mask, 0);

      // Backpressure: WRITE held for 5 cycles.
      wr_before = n_wr;
      run_cmd(WR, 32'h0, 32'h7777, 1'b1, 2, 32'h0, 1'b1, 5);
      chk("bp_write_pulses", n_wr - wr_before, 1);

      // Random opcode run, pulse counts against issued opcodes.
      n_ps = 0; n_ts = 0; n_tc = 0; n_sf = 0; n_rd = 0; n_wr = 0;
      e_ps = 0; e_ts = 0; e_tc = 0; e_sf = 0; e_rd = 0; e_wr = 0;
      for (int i = 0; i < 200; i++) begin
         op = 3'($urandom_range(0, 7));
         d  = $urandom;
         rl = $urandom;
         am = 1'($urandom_range(0, 1));
         case (op)
            SRCH: begin e_ps += SC; e_ts++; end
            CLR:  e_tc++;
            SELF: e_sf++;
            RD:   e_rd++;
            WR:   e_wr++;
            default: ;
         endcase
         run_cmd(op, d, rl, am, lat_of(op), (op == RD) ? rl : '0, am, 0);
      end
      chk("cnt_perform_search", n_ps, e_ps);
      chk("cnt_tag_set", n_ts, e_ts);
      chk("cnt_tag_clear", n_tc, e_tc);
      chk("cnt_select_first", n_sf, e_sf);
      chk("cnt_read_en", n_rd, e_rd);
      chk("cnt_write_en", n_wr, e_wr);
      chk("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
